// File: rtl/inst_mem.sv
// Word-organised 32-bit instruction memory: combinational byte-addressed read,
// single-word synchronous write, synchronous clear of the whole array.
module inst_mem #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned ADDR_LSB = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        memWrite,
    input  logic [31:0] Data_in,
    output logic [31:0] Data_out
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      word_addr;
    logic [IDX_W-1:0] index;
    logic             in_range;

    // Any set bit above the index field means out of range, so there is no aliasing.
    always_comb begin
        word_addr = address >> ADDR_LSB;
        index     = word_addr[IDX_W-1:0];
        in_range  = ((word_addr >> IDX_W) == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (memWrite && in_range) begin
            mem_q[index] <= Data_in;
        end
    end

    assign Data_out = in_range ? mem_q[index] : '0;

endmodule

// File: tb/tb_inst_mem.sv
// Scoreboard bench for inst_mem: stimulus queues expected read data, a
// monitor pops and compares it on the falling edge of each cycle.
module tb_inst_mem;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic        memWrite;
    logic [31:0] Data_in;
    logic [31:0] Data_out;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       asserts = 0;
    int       fails   = 0;
    bit       done    = 1'b0;

    inst_mem #(
        .DEPTH   (256),
        .ADDR_LSB(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .memWrite(memWrite),
        .Data_in (Data_in),
        .Data_out(Data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs just after the rising edge and queue the value
    // Data_out must show before the next rising edge.
    task automatic op(input logic rst, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] exp, input string name);
        @(posedge clk);
        #1;
        reset    = rst;
        memWrite = we;
        address  = addr;
        Data_in  = data;
        sb_q.push_back('{name: name, addr: addr, exp: exp});
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        op(1'b0, 1'b0, addr, 32'h0, exp, name);
    endtask

    // Monitor: read data is valid throughout the low phase of each cycle.
    initial begin
        sb_item_t it;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                asserts++;
                if (Data_out !== it.exp) begin
                    fails++;
                    $display("FAIL %s: addr=%08h Data_out=%08h expected=%08h",
                             it.name, it.addr, Data_out, it.exp);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        memWrite = 1'b0;
        address  = '0;
        Data_in  = '0;
        @(posedge clk);
        #1;

        // Reset held with a write request: array stays cleared.
        op(1'b1, 1'b1, 32'h0000_0008, 32'h1111_1111, 32'h0, "rst_hold_read");
        rd(32'h0000_0008, 32'h0, "rst_write_ignored");
        rd(32'h0000_0000, 32'h0, "rst_addr_000");
        rd(32'h0000_0004, 32'h0, "rst_addr_004");
        rd(32'h0000_03FC, 32'h0, "rst_addr_3fc");

        // Basic write; pre-edge read shows the old value (no bypass).
        op(1'b0, 1'b1, 32'h0000_0004, 32'h1234_5678, 32'h0, "wr4_pre_edge");
        rd(32'h0000_0004, 32'h1234_5678, "rd_addr_004");
        rd(32'h0000_0000, 32'h0, "rd_addr_000");
        rd(32'h0000_0008, 32'h0, "rd_addr_008");
        rd(32'h0000_0006, 32'h1234_5678, "rd_misalign_6");
        rd(32'h0000_0007, 32'h1234_5678, "rd_misalign_7");

        // Out-of-range write is dropped and does not alias.
        op(1'b0, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0, "oor_pre_edge");
        rd(32'h0000_0400, 32'h0, "oor_read_400");
        rd(32'h0000_0000, 32'h0, "oor_no_alias_000");
        rd(32'h0000_0004, 32'h1234_5678, "oor_keep_004");
        rd(32'h8000_0004, 32'h0, "oor_high_bit");

        // Back-to-back writes to the same word: last wins.
        op(1'b0, 1'b1, 32'h0000_0010, 32'hAAAA_5555, 32'h0, "b2b_first_pre");
        op(1'b0, 1'b1, 32'h0000_0010, 32'h0F0F_0F0F, 32'hAAAA_5555, "b2b_second_pre");
        rd(32'h0000_0010, 32'h0F0F_0F0F, "b2b_last_wins");

        // Top word of the array.
        op(1'b0, 1'b1, 32'h0000_03FC, 32'hFEED_FACE, 32'h0, "top_pre_edge");
        rd(32'h0000_03FD, 32'hFEED_FACE, "top_read_3fd");
        rd(32'h0000_0010, 32'h0F0F_0F0F, "top_keep_010");

        // Reset beats a simultaneous write.
        op(1'b1, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 32'h1234_5678, "rstwr_pre_edge");
        rd(32'h0000_0004, 32'h0, "rstwr_004_cleared");
        rd(32'h0000_0010, 32'h0, "rstwr_010_cleared");
        rd(32'h0000_03FC, 32'h0, "rstwr_3fc_cleared");

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            asserts++;
            fails++;
            $display("FAIL sb_drain: pending=%0d expected=0", sb_q.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: time=%0t expected=finish before 100000", $time);
            $fatal(1, "watchdog expired");
        end
    end

endmodule
